conv1d_sram_arbiter: RTL and testbench

- Arbitrates the single-port conv1d internal SRAM (128 x 32 bit) between two requesters:
  - the host side, i.e. the OBI-to-SRAM bridge;
  - the accelerator datapath.
- Replaces the ad-hoc ext_mem_gnt wiring with fair round-robin sharing.
- Supports an accelerator lock that excludes the host while a convolution is running.
- Sits between the bridge/accelerator and conv1d_sram_wrapper inside conv1d.

---
 rtl/conv1d_arb_pkg.sv | 6 +
 rtl/conv1d_arb_rsp_track.sv | 34 +++
 rtl/conv1d_sram_arbiter.sv | 102 ++++++++++
 tb/tb_conv1d_sram_arbiter.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/conv1d_arb_pkg.sv
// conv1d_arb_pkg: shared types and constants for the conv1d SRAM arbiter
package conv1d_arb_pkg;
   typedef enum logic [1:0] {ARB, LOCKED, UNLOCK} arb_state_e;
   typedef enum logic {HOST = 1'b0, ACC = 1'b1} requester_e;
   localparam int StallCntWidth = 16;
endpackage

// File: rtl/conv1d_arb_rsp_track.sv
// conv1d_arb_rsp_track: one-cycle response tracking and read-data routing
module conv1d_arb_rsp_track
   import conv1d_arb_pkg::*;
#(
   parameter int DataWidth = 32
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 host_gnt,
   input  logic                 acc_gnt,
   input  logic [DataWidth-1:0] sram_rdata,
   output logic                 host_rvalid,
   output logic                 acc_rvalid,
   output logic [DataWidth-1:0] host_rdata,
   output logic [DataWidth-1:0] acc_rdata
);
   requester_e owner_q;
   logic       rsp;
   // remember who was granted so the next-cycle SRAM word reaches the right side
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         owner_q     <= HOST;
         host_rvalid <= 1'b0;
         acc_rvalid  <= 1'b0;
      end else begin
         host_rvalid <= host_gnt;
         acc_rvalid  <= acc_gnt;
         if (host_gnt || acc_gnt) owner_q <= acc_gnt ? ACC : HOST;
      end
   end
   assign rsp        = host_rvalid | acc_rvalid;
   assign host_rdata = (rsp && owner_q == HOST) ? sram_rdata : '0;
   assign acc_rdata  = (rsp && owner_q == ACC) ? sram_rdata : '0;
endmodule

// File: rtl/conv1d_sram_arbiter.sv
// conv1d_sram_arbiter: round-robin host/accelerator arbiter for the conv1d SRAM with accelerator lock (optional stall stats via CONV1D_ARB_STATS_EN)
module conv1d_sram_arbiter
   import conv1d_arb_pkg::*;
#(
   parameter int DataWidth = 32,
   parameter int AddrWidth = 7
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   host_req_i,
   input  logic                   host_we_i,
   input  logic [AddrWidth-1:0]   host_addr_i,
   input  logic [DataWidth-1:0]   host_wdata_i,
   input  logic [DataWidth/8-1:0] host_be_i,
   output logic                   host_gnt_o,
   output logic                   host_rvalid_o,
   output logic [DataWidth-1:0]   host_rdata_o,
   input  logic                   acc_req_i,
   input  logic                   acc_we_i,
   input  logic [AddrWidth-1:0]   acc_addr_i,
   input  logic [DataWidth-1:0]   acc_wdata_i,
   input  logic [DataWidth/8-1:0] acc_be_i,
   output logic                   acc_gnt_o,
   output logic                   acc_rvalid_o,
   output logic [DataWidth-1:0]   acc_rdata_o,
   input  logic                   acc_lock_i,
   output logic                   locked_o,
`ifdef CONV1D_ARB_STATS_EN
   input  logic                   stats_clr_i,
   output logic [StallCntWidth-1:0] host_stall_cnt_o,
`endif
   output logic                   sram_req_o,
   output logic                   sram_we_o,
   output logic [AddrWidth-1:0]   sram_addr_o,
   output logic [DataWidth-1:0]   sram_wdata_o,
   output logic [DataWidth/8-1:0] sram_be_o,
   input  logic [DataWidth-1:0]   sram_rdata_i
);
   arb_state_e state_q, state_d;
   requester_e last_q, last_d;
   // state and round-robin history
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= ARB;
         last_q  <= ACC;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
      end
   end
   // grant decision and next state; lock always beats the host in the same cycle
   always_comb begin
      state_d    = state_q;
      last_d     = last_q;
      host_gnt_o = 1'b0;
      acc_gnt_o  = 1'b0;
      case (state_q)
         ARB: begin
            host_gnt_o = host_req_i && !acc_lock_i && (!acc_req_i || last_q == ACC);
            acc_gnt_o  = acc_req_i && !host_gnt_o;
            if (acc_lock_i) state_d = LOCKED;
         end
         LOCKED: begin
            acc_gnt_o = acc_req_i;
            if (!acc_lock_i) state_d = UNLOCK;
         end
         UNLOCK: begin
            host_gnt_o = host_req_i && !acc_lock_i;
            acc_gnt_o  = acc_req_i && !host_gnt_o;
            state_d    = acc_lock_i ? LOCKED : ARB;
         end
         default: state_d = ARB;
      endcase
      if (host_gnt_o || acc_gnt_o) last_d = acc_gnt_o ? ACC : HOST;
      if (state_q == UNLOCK) last_d = HOST;
   end
   assign locked_o     = state_q == LOCKED;
   assign sram_req_o   = host_gnt_o | acc_gnt_o;
   assign sram_we_o    = host_gnt_o ? host_we_i : acc_gnt_o & acc_we_i;
   assign sram_addr_o  = host_gnt_o ? host_addr_i : acc_gnt_o ? acc_addr_i : '0;
   assign sram_wdata_o = host_gnt_o ? host_wdata_i : acc_gnt_o ? acc_wdata_i : '0;
   assign sram_be_o    = host_gnt_o ? host_be_i : acc_gnt_o ? acc_be_i : '0;
   conv1d_arb_rsp_track #(.DataWidth(DataWidth)) u_rsp (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .host_gnt   (host_gnt_o),
      .acc_gnt    (acc_gnt_o),
      .sram_rdata (sram_rdata_i),
      .host_rvalid(host_rvalid_o),
      .acc_rvalid (acc_rvalid_o),
      .host_rdata (host_rdata_o),
      .acc_rdata  (acc_rdata_o)
   );
`ifdef CONV1D_ARB_STATS_EN
   // saturating count of cycles the host waits; clear wins over increment
   always_ff @(posedge clk_i) begin
      if (!rst_ni || stats_clr_i) host_stall_cnt_o <= '0;
      else if (host_req_i && !host_gnt_o && host_stall_cnt_o != '1)
         host_stall_cnt_o <= host_stall_cnt_o + StallCntWidth'(1);
   end
`endif
endmodule

// File: tb/tb_conv1d_sram_arbiter.sv
// tb_conv1d_sram_arbiter: directed self-checking bench for conv1d_sram_arbiter
module tb_conv1d_sram_arbiter;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        host_req = 1'b0, host_we = 1'b0, acc_req = 1'b0, acc_we = 1'b0, acc_lock = 1'b0;
   logic [6:0]  host_addr = '0, acc_addr = '0;
   logic [31:0] host_wdata = '0, acc_wdata = '0;
   logic [3:0]  host_be = 4'hF, acc_be = 4'hF;
   logic        host_gnt, host_rvalid, acc_gnt, acc_rvalid, locked;
   logic [31:0] host_rdata, acc_rdata;
   logic        sram_req, sram_we;
   logic [6:0]  sram_addr;
   logic [31:0] sram_wdata;
   logic [3:0]  sram_be;
   logic [31:0] sram_rdata = '0;
   logic [31:0] mem [128];
   int          checks = 0;
   int          failures = 0;
`ifdef CONV1D_ARB_STATS_EN
   logic        stats_clr = 1'b0;
   logic [15:0] stall_cnt;
`endif

   conv1d_sram_arbiter dut (
      .clk_i(clk), .rst_ni(rst_n),
      .host_req_i(host_req), .host_we_i(host_we), .host_addr_i(host_addr),
      .host_wdata_i(host_wdata), .host_be_i(host_be),
      .host_gnt_o(host_gnt), .host_rvalid_o(host_rvalid), .host_rdata_o(host_rdata),
      .acc_req_i(acc_req), .acc_we_i(acc_we), .acc_addr_i(acc_addr),
      .acc_wdata_i(acc_wdata), .acc_be_i(acc_be),
      .acc_gnt_o(acc_gnt), .acc_rvalid_o(acc_rvalid), .acc_rdata_o(acc_rdata),
      .acc_lock_i(acc_lock), .locked_o(locked),
`ifdef CONV1D_ARB_STATS_EN
      .stats_clr_i(stats_clr), .host_stall_cnt_o(stall_cnt),
`endif
      .sram_req_o(sram_req), .sram_we_o(sram_we), .sram_addr_o(sram_addr),
      .sram_wdata_o(sram_wdata), .sram_be_o(sram_be), .sram_rdata_i(sram_rdata)
   );

   always #5 clk = ~clk;

   // behavioural single-port SRAM: one-cycle read latency, byte-enabled writes
   always @(posedge clk) begin
      if (!rst_n) begin
         mem[3]  <= 32'hDEADBEEF;
         mem[5]  <= 32'h0505A5A5;
         mem[9]  <= 32'h0909C3C3;
         mem[10] <= 32'hFFFFFFFF;
      end else if (sram_req) begin
         sram_rdata <= mem[sram_addr];
         if (sram_we)
            for (int b = 0; b < 4; b++)
               if (sram_be[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      end
   end

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic hr, input logic hw, input logic [6:0] ha,
                        input logic ar, input logic aw, input logic [6:0] aa, input logic lk);
      @(negedge clk);
      host_req = hr; host_we = hw; host_addr = ha;
      acc_req = ar; acc_we = aw; acc_addr = aa; acc_lock = lk;
      #1;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk1("rst_host_rvalid", host_rvalid, 1'b0);
      chk1("rst_acc_rvalid", acc_rvalid, 1'b0);
      chk1("rst_locked", locked, 1'b0);
      chk1("rst_sram_req", sram_req, 1'b0);
      chk1("rst_host_gnt", host_gnt, 1'b0);
`ifdef CONV1D_ARB_STATS_EN
      chk32("rst_stall_cnt", {16'h0, stall_cnt}, 32'h0);
`endif
      rst_n = 1'b1;
      // reset while a host read response is pending
      drive(1, 0, 5, 0, 0, 0, 0);
      chk1("mid_host_gnt", host_gnt, 1'b1);
      chk32("mid_sram_addr", {25'h0, sram_addr}, 32'd5);
      drive(0, 0, 0, 0, 0, 0, 0);
      rst_n = 1'b0;
      chk1("mid_rvalid_before_rst", host_rvalid, 1'b1);
      drive(0, 0, 0, 0, 0, 0, 0);
      chk1("mid_rvalid_dropped", host_rvalid, 1'b0);
      chk32("mid_host_rdata", host_rdata, 32'h0);
      chk1("mid_acc_rvalid", acc_rvalid, 1'b0);
      chk1("mid_sram_req", sram_req, 1'b0);
      rst_n = 1'b1;
      // contention from reset: host first because last winner resets to ACC
      drive(1, 0, 5, 1, 0, 9, 0);
      chk1("ct0_host_gnt", host_gnt, 1'b1);
      chk1("ct0_acc_gnt", acc_gnt, 1'b0);
      chk32("ct0_addr", {25'h0, sram_addr}, 32'd5);
      drive(1, 0, 5, 1, 0, 9, 0);
      chk1("ct1_acc_gnt", acc_gnt, 1'b1);
      chk1("ct1_host_gnt", host_gnt, 1'b0);
      chk32("ct1_addr", {25'h0, sram_addr}, 32'd9);
      chk1("ct1_host_rvalid", host_rvalid, 1'b1);
      chk32("ct1_host_rdata", host_rdata, 32'h0505A5A5);
      chk32("ct1_acc_rdata", acc_rdata, 32'h0);
      drive(1, 0, 5, 1, 0, 9, 0);
      chk1("ct2_host_gnt", host_gnt, 1'b1);
      chk1("ct2_acc_rvalid", acc_rvalid, 1'b1);
      chk32("ct2_acc_rdata", acc_rdata, 32'h0909C3C3);
      chk32("ct2_host_rdata", host_rdata, 32'h0);
      drive(1, 0, 5, 1, 0, 9, 0);
      chk1("ct3_acc_gnt", acc_gnt, 1'b1);
      chk1("ct3_host_rvalid", host_rvalid, 1'b1);
      chk32("ct3_host_rdata", host_rdata, 32'h0505A5A5);
      drive(0, 0, 0, 0, 0, 0, 0);
      chk1("ct4_acc_rvalid", acc_rvalid, 1'b1);
      chk32("ct4_acc_rdata", acc_rdata, 32'h0909C3C3);
      chk1("idle_sram_req", sram_req, 1'b0);
      chk32("idle_sram_addr", {25'h0, sram_addr}, 32'h0);
      // lock held 10 cycles while the host keeps requesting
      for (int i = 0; i < 10; i++) begin
         drive(1, 0, 3, 0, 0, 0, 1);
         chk1("lk_host_gnt", host_gnt, 1'b0);
         chk1("lk_locked", locked, i >= 1);
      end
      drive(1, 0, 3, 0, 0, 0, 0);
      chk1("lk_release_locked", locked, 1'b1);
      chk1("lk_release_host_gnt", host_gnt, 1'b0);
      drive(1, 0, 3, 0, 0, 0, 0);
      chk1("unlock_locked", locked, 1'b0);
      chk1("unlock_host_gnt", host_gnt, 1'b1);
      drive(0, 0, 0, 0, 0, 0, 0);
      chk1("unlock_rvalid", host_rvalid, 1'b1);
      chk32("unlock_rdata", host_rdata, 32'hDEADBEEF);
      // lock rises the cycle after a host grant
      drive(1, 0, 3, 0, 0, 0, 0);
      chk1("race_host_gnt", host_gnt, 1'b1);
      drive(1, 0, 3, 0, 0, 0, 1);
      chk1("race_host_blocked", host_gnt, 1'b0);
      chk1("race_rvalid", host_rvalid, 1'b1);
      chk32("race_rdata", host_rdata, 32'hDEADBEEF);
      drive(1, 0, 3, 1, 0, 9, 1);
      chk1("race_locked", locked, 1'b1);
      chk1("race_host_gnt2", host_gnt, 1'b0);
      chk1("race_acc_gnt", acc_gnt, 1'b1);
      drive(0, 0, 0, 0, 0, 0, 0);
      chk1("race_locked2", locked, 1'b1);
      chk1("race_acc_rvalid", acc_rvalid, 1'b1);
      chk32("race_acc_rdata", acc_rdata, 32'h0909C3C3);
      drive(0, 0, 0, 0, 0, 0, 0);
      chk1("race_unlock", locked, 1'b0);
      // partial acc write then host read back
      acc_wdata = 32'h12345678;
      acc_be = 4'b0011;
      drive(0, 0, 0, 1, 1, 10, 0);
      chk1("wr_acc_gnt", acc_gnt, 1'b1);
      chk1("wr_sram_we", sram_we, 1'b1);
      chk32("wr_sram_be", {28'h0, sram_be}, 32'h3);
      chk32("wr_sram_wdata", sram_wdata, 32'h12345678);
      drive(1, 0, 10, 0, 0, 0, 0);
      chk1("wr_acc_rvalid", acc_rvalid, 1'b1);
      chk1("rd_host_gnt", host_gnt, 1'b1);
      chk1("rd_sram_we", sram_we, 1'b0);
      drive(0, 0, 0, 0, 0, 0, 0);
      chk1("rd_host_rvalid", host_rvalid, 1'b1);
      chk32("rd_host_rdata", host_rdata, 32'hFFFF5678);
`ifdef CONV1D_ARB_STATS_EN
      stats_clr = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0);
      stats_clr = 1'b0;
      chk32("st_cleared", {16'h0, stall_cnt}, 32'h0);
      for (int i = 0; i < 7; i++) drive(1, 0, 3, 0, 0, 0, 1);
      drive(0, 0, 0, 0, 0, 0, 1);
      chk32("st_count7", {16'h0, stall_cnt}, 32'd7);
      stats_clr = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 1);
      stats_clr = 1'b0;
      chk32("st_clr", {16'h0, stall_cnt}, 32'h0);
      drive(0, 0, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0);
      chk1("st_unlocked", locked, 1'b0);
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
